// File: rtl/sprite_engine.sv
// sprite_engine: multi-sprite erase/move/redraw engine streaming pixels to a VGA plot port.
// Ports: clock/reset (sync, active-high); run gates the frame counter;
// cfg_* write one sprite slot while idle; plot_ready accepts the current pixel;
// x/y/colour/plot form the registered pixel stream; busy marks a frame pass,
// frame_done pulses at its end; retired holds sticky per-slot limit flags;
// overrun is sticky when a tick lands during a pass.
module sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int DX_W = 4,
  parameter int X_LIMIT = 100,
  parameter int WRAP = 0,
  parameter int BG_COLOUR = 0,
  parameter int FRAME_CYCLES = 833333,
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   cfg_we,
  input  logic [IW-1:0]          cfg_idx,
  input  logic [X_W-1:0]         cfg_x,
  input  logic [Y_W-1:0]         cfg_y,
  input  logic [DX_W-1:0]        cfg_dx,
  input  logic [2:0]             cfg_colour,
  input  logic                   cfg_en,
  input  logic                   plot_ready,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic [NUM_SPRITES-1:0] retired,
  output logic                   overrun
);
  localparam int NPIX = SPR_W * SPR_H;
  localparam int PW = $clog2(NPIX) + 1;
  localparam int FW = $clog2(FRAME_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, ERASE = 3'd2, MOVE = 3'd3, DRAW = 3'd4, DONE = 3'd5;
  logic [2:0] state;
  logic [IW-1:0] idx;
  logic [PW-1:0] pix;
  logic [FW-1:0] fc;
  logic [X_W-1:0] sx [NUM_SPRITES];
  logic [Y_W-1:0] sy [NUM_SPRITES];
  logic signed [DX_W-1:0] sdx [NUM_SPRITES];
  logic [2:0] scol [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sen;
  logic tick, last, fits;
  logic signed [X_W:0] nx;
  logic [X_W-1:0] nxw;
  int m;
  assign tick = run && fc == FW'(FRAME_CYCLES - 1);
  assign last = idx == IW'(NUM_SPRITES - 1);
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  function automatic logic [X_W-1:0] col_x(input logic [X_W-1:0] bx, input logic [PW-1:0] p);
    return bx + X_W'(p % PW'(SPR_W));
  endfunction
  function automatic logic [Y_W-1:0] row_y(input logic [Y_W-1:0] by, input logic [PW-1:0] p);
    return by + Y_W'(p / PW'(SPR_W));
  endfunction
  // Next x of the current slot; the modulo path only matters when WRAP is set.
  always_comb begin
    nx = $signed({1'b0, sx[idx]}) + (X_W+1)'(sdx[idx]);
    fits = !nx[X_W] && nx[X_W-1:0] <= X_W'(X_LIMIT);
    m = int'(nx) % (X_LIMIT + 1);
    m = m < 0 ? m + X_LIMIT + 1 : m;
    nxw = fits ? nx[X_W-1:0] : X_W'(m);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      pix <= '0;
      fc <= '0;
      sen <= '0;
      retired <= '0;
      overrun <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
        sdx[i] <= '0;
        scol[i] <= '0;
      end
    end else begin
      fc <= (!run || tick) ? '0 : fc + 1'b1;
      if (tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            sx[cfg_idx] <= cfg_x;
            sy[cfg_idx] <= cfg_y;
            sdx[cfg_idx] <= cfg_dx;
            scol[cfg_idx] <= cfg_colour;
            sen[cfg_idx] <= cfg_en;
            retired[cfg_idx] <= 1'b0;
          end
          if (tick) begin
            idx <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (sen[idx]) begin
            state <= ERASE;
            pix <= '0;
            x <= sx[idx];
            y <= sy[idx];
            colour <= 3'(BG_COLOUR);
            plot <= 1'b1;
          end else begin
            state <= last ? DONE : SCAN;
            idx <= idx + 1'b1;
          end
        end
        ERASE, DRAW: begin
          if (plot_ready) begin
            if (pix == PW'(NPIX - 1)) begin
              plot <= 1'b0;
              state <= state == ERASE ? MOVE : last ? DONE : SCAN;
              if (state == DRAW) idx <= idx + 1'b1;
            end else begin
              pix <= pix + 1'b1;
              x <= col_x(sx[idx], pix + 1'b1);
              y <= row_y(sy[idx], pix + 1'b1);
            end
          end
        end
        MOVE: begin
          if (fits || WRAP != 0) begin
            sx[idx] <= nxw;
            state <= DRAW;
            pix <= '0;
            x <= nxw;
            y <= sy[idx];
            colour <= scol[idx];
            plot <= 1'b1;
          end else begin
            sen[idx] <= 1'b0;
            retired[idx] <= 1'b1;
            state <= last ? DONE : SCAN;
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: scoreboard bench running a WRAP=0 and a WRAP=1 engine side by side.
module tb_sprite_engine;
  localparam int N = 4, S = 16, L = 101;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  logic clock = 0, reset = 1, run = 0, cfg_we = 0, cfg_en = 0, plot_ready = 1;
  logic [1:0] cfg_idx = 0;
  logic [7:0] cfg_x = 0;
  logic [6:0] cfg_y = 0;
  logic [3:0] cfg_dx = 0;
  logic [2:0] cfg_colour = 0;
  logic [7:0] ox [2];
  logic [6:0] oy [2];
  logic [2:0] oc [2];
  logic op [2], ob [2], ofd [2], oov [2];
  logic [3:0] oret [2];
  pix_t q0[$], q1[$];
  int compared = 0, mismatched = 0;
  int mx [2][N], my [2][N], mdx [2][N], mc [2][N];
  logic [N-1:0] men [2], mret [2];
  logic mov [2];
  int elen [2], bcnt [2], scnt [2], fdcnt [2], xfer [2];
  pix_t last_p [2];
  logic stl [2];
  always #5 clock = ~clock;
  sprite_engine #(.FRAME_CYCLES(64), .WRAP(0)) dut0 (
    .clock(clock), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_dx(cfg_dx), .cfg_colour(cfg_colour), .cfg_en(cfg_en), .plot_ready(plot_ready),
    .x(ox[0]), .y(oy[0]), .colour(oc[0]), .plot(op[0]), .busy(ob[0]), .frame_done(ofd[0]),
    .retired(oret[0]), .overrun(oov[0]));
  sprite_engine #(.FRAME_CYCLES(64), .WRAP(1)) dut1 (
    .clock(clock), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_dx(cfg_dx), .cfg_colour(cfg_colour), .cfg_en(cfg_en), .plot_ready(plot_ready),
    .x(ox[1]), .y(oy[1]), .colour(oc[1]), .plot(op[1]), .busy(ob[1]), .frame_done(ofd[1]),
    .retired(oret[1]), .overrun(oov[1]));
  function automatic void chk(string n, int got, int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endfunction
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic push(int d, int px, int py, int c);
    pix_t e;
    e.x = 8'(px);
    e.y = 7'(py);
    e.c = 3'(c);
    if (d == 1) q1.push_back(e);
    else q0.push_back(e);
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        mx[d][i] = 0; my[d][i] = 0; mdx[d][i] = 0; mc[d][i] = 0;
      end
      men[d] = '0; mret[d] = '0; mov[d] = 0;
    end
  endtask
  // Whole-frame reference: every enabled sprite is erased, stepped, and redrawn in index order.
  task automatic model_pass();
    for (int d = 0; d < 2; d++) begin
      elen[d] = N + 1;
      for (int i = 0; i < N; i++) begin
        int nx;
        if (!men[d][i]) continue;
        for (int p = 0; p < S; p++) push(d, mx[d][i] + p % 4, my[d][i] + p / 4, 0);
        elen[d] += S + 1;
        nx = mx[d][i] + mdx[d][i];
        if (nx >= 0 && nx < L) mx[d][i] = nx;
        else if (d == 1) mx[d][i] = ((nx % L) + L) % L;
        else begin
          men[d][i] = 0;
          mret[d][i] = 1;
          continue;
        end
        for (int p = 0; p < S; p++) push(d, mx[d][i] + p % 4, my[d][i] + p / 4, mc[d][i]);
        elen[d] += S;
      end
    end
  endtask
  task automatic wr(int i, int px, int py, int dx, int c, bit en);
    cfg_idx = 2'(i); cfg_x = 8'(px); cfg_y = 7'(py); cfg_dx = 4'(dx); cfg_colour = 3'(c); cfg_en = en;
    cfg_we = 1;
    cyc();
    cfg_we = 0;
    for (int d = 0; d < 2; d++) begin
      mx[d][i] = px; my[d][i] = py; mdx[d][i] = dx; mc[d][i] = c; men[d][i] = en; mret[d][i] = 0;
    end
  endtask
  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      bcnt[d] = 0; scnt[d] = 0; fdcnt[d] = 0; xfer[d] = 0;
    end
  endtask
  task automatic start_pass(bit keep_run);
    int t = 0;
    clear_counts();
    run = 1;
    while (!ob[0] && t < 200) begin
      cyc();
      t++;
    end
    chk("pass_start", int'(ob[0]), 1);
    if (!keep_run) run = 0;
  endtask
  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random stalls
  task automatic do_pass(int mode, bit keep_run, bit busy_wr);
    int t = 0;
    model_pass();
    start_pass(keep_run);
    while (!(fdcnt[0] > 0 && fdcnt[1] > 0) && t < 3000) begin
      plot_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 4 == 0 || t % 4 == 3) : ($urandom_range(99) < 60);
      if (busy_wr && t == 10) begin
        cfg_idx = 1; cfg_x = 50; cfg_y = 9; cfg_dx = 3; cfg_colour = 7; cfg_en = 1; cfg_we = 1;
      end else cfg_we = 0;
      cyc();
      t++;
    end
    run = 0; plot_ready = 1; cfg_we = 0;
    for (int d = 0; d < 2; d++) if (keep_run && elen[d] >= 64) mov[d] = 1;
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("frame_done_count dut%0d", d), fdcnt[d], 1);
      chk($sformatf("pass_length dut%0d", d), bcnt[d] - scnt[d], elen[d]);
      chk($sformatf("missing_pixels dut%0d", d), d ? q1.size() : q0.size(), 0);
      chk($sformatf("retired dut%0d", d), int'(oret[d]), int'(mret[d]));
      chk($sformatf("overrun dut%0d", d), int'(oov[d]), int'(mov[d]));
    end
  endtask
  always @(negedge clock) begin
    if (reset) begin
      stl[0] = 0;
      stl[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        pix_t cur, e;
        cur = {ox[d], oy[d], oc[d]};
        if (ob[d]) bcnt[d]++;
        if (ofd[d]) fdcnt[d]++;
        if (stl[d]) begin
          compared++;
          if (!op[d] || cur != last_p[d]) begin
            mismatched++;
            $display("FAIL hold dut%0d: got plot=%0d x=%0d y=%0d c=%0d want plot=1 x=%0d y=%0d c=%0d",
                     d, op[d], cur.x, cur.y, cur.c, last_p[d].x, last_p[d].y, last_p[d].c);
          end
        end
        stl[d] = op[d] && !plot_ready;
        last_p[d] = cur;
        if (stl[d]) scnt[d]++;
        if (op[d] && plot_ready) begin
          xfer[d]++;
          compared++;
          if ((d == 1 ? q1.size() : q0.size()) == 0) begin
            mismatched++;
            $display("FAIL pixel dut%0d: got x=%0d y=%0d c=%0d want no pixel", d, cur.x, cur.y, cur.c);
          end else begin
            if (d == 1) e = q1.pop_front();
            else e = q0.pop_front();
            if (cur != e) begin
              mismatched++;
              $display("FAIL pixel dut%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                       d, cur.x, cur.y, cur.c, e.x, e.y, e.c);
            end
          end
        end
      end
    end
  end
  initial begin
    int t;
    model_reset();
    repeat (3) cyc();
    reset = 0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_plot", int'(op[d]), 0);
      chk("reset_busy", int'(ob[d]), 0);
      chk("reset_frame_done", int'(ofd[d]), 0);
      chk("reset_retired", int'(oret[d]), 0);
      chk("reset_overrun", int'(oov[d]), 0);
      chk("reset_xyc", int'({ox[d], oy[d], oc[d]}), 0);
    end
    // single sprite, one step right
    wr(0, 10, 58, 1, 2, 1);
    do_pass(0, 0, 0);
    chk("first_pass_38", bcnt[0], 38);
    // at the limit: retire without wrap, wrap to 0 with it
    wr(0, 100, 10, 1, 4, 1);
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    // wrap both directions
    wr(0, 99, 20, 3, 6, 1);
    do_pass(0, 0, 0);
    wr(0, 1, 20, -2, 6, 1);
    do_pass(0, 0, 0);
    // stalled handshake
    wr(0, 40, 40, 2, 1, 1);
    do_pass(1, 0, 0);
    // long pass with ticks landing mid-pass and a config write while busy
    for (int i = 0; i < N; i++) wr(i, 10 + 20 * i, 5 + 30 * i, 1, i + 1, 1);
    do_pass(0, 1, 1);
    do_pass(0, 0, 0);
    // randomized slot contents and stalls
    repeat (6) begin
      for (int i = 0; i < N; i++)
        wr(i, $urandom_range(100), $urandom_range(127), int'($urandom_range(15)) - 8,
           $urandom_range(7), 1'($urandom_range(1)));
      do_pass($urandom_range(2), 0, 0);
    end
    // reset in the middle of a draw
    wr(2, 100, 5, 1, 3, 1);
    do_pass(0, 0, 0);
    wr(0, 20, 30, -1, 5, 1);
    model_pass();
    start_pass(0);
    t = 0;
    while (xfer[0] < 18 && t < 200) begin
      cyc();
      t++;
    end
    chk("reached_draw", int'(xfer[0] >= 18), 1);
    reset = 1;
    q0.delete();
    q1.delete();
    model_reset();
    cyc();
    reset = 0;
    for (int d = 0; d < 2; d++) begin
      chk("midreset_plot", int'(op[d]), 0);
      chk("midreset_busy", int'(ob[d]), 0);
      chk("midreset_retired", int'(oret[d]), 0);
    end
    do_pass(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
